// File: rtl/textbuf_pkg.sv
// Shared constants and types for the text-buffer access controller.
// Holds the default text geometry, the derived address width and the
// clear-engine state encoding.
package textbuf_pkg;

  localparam int unsigned COLS_DEF   = 80;
  localparam int unsigned ROWS_DEF   = 60;
  localparam int unsigned CHAR_W_DEF = 8;
  localparam int unsigned ADDR_W     = $clog2(COLS_DEF * ROWS_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/textbuf_wr_fifo.sv
// Synchronous host-write queue.
// Ports: clk/rst (async active-high), flush (empties the queue, wins over push),
// push/push_data, pop, head (oldest entry), full, empty.
// Pointers carry one extra wrap bit so full and empty come straight from them.
module textbuf_wr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Pointer update; flush returns both pointers to the origin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{PW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{PW{1'b0}}, 1'b1};
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[PW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/textbuf_access_ctrl.sv
// Arbitrates the text buffer between video fetch, a clear-screen engine and
// queued host writes. Video fetch always wins, with zero latency.
// Ports: clk, rst (async active-high); vid_active_i/vid_addr_i (video fetch);
// host_valid_i/host_ready_o/host_addr_i/host_data_i (host write handshake);
// clear_req_i/clear_busy_o (clear screen); buf_en_o/buf_we_o/buf_addr_o/
// buf_data_o (buffer port, combinational); drop_o (out-of-range host write).
// Build option: define TEXTBUF_CLEAR_EN to include the clear engine.
module textbuf_access_ctrl #(
  parameter int unsigned COLS       = textbuf_pkg::COLS_DEF,
  parameter int unsigned ROWS       = textbuf_pkg::ROWS_DEF,
  parameter int unsigned CHAR_W     = textbuf_pkg::CHAR_W_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [CHAR_W-1:0] FILL_CHAR = CHAR_W'(8'h20),
  localparam int unsigned ADDR_W    = $clog2(COLS * ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_active_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  input  logic              host_valid_i,
  output logic              host_ready_o,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [CHAR_W-1:0] host_data_i,
  input  logic              clear_req_i,
  output logic              clear_busy_o,
  output logic              buf_en_o,
  output logic              buf_we_o,
  output logic [ADDR_W-1:0] buf_addr_o,
  output logic [CHAR_W-1:0] buf_data_o,
  output logic              drop_o
);

  import textbuf_pkg::*;

  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned ENT_W = ADDR_W + CHAR_W;

  logic              accept;
  logic              in_range;
  logic              flush;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ENT_W-1:0]  head;
  logic              clearing;
  logic [ADDR_W-1:0] clr_addr;

  assign accept   = host_valid_i && host_ready_o;
  assign in_range = 32'(host_addr_i) < CELLS;

`ifdef TEXTBUF_CLEAR_EN
  clr_state_t        state;
  logic [ADDR_W-1:0] clr_cnt;

  // Clear engine: counter only advances on cycles the buffer is free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else if (state == IDLE) begin
      if (clear_req_i) begin
        state   <= CLEAR;
        clr_cnt <= '0;
      end
    end else if (!vid_active_i) begin
      if (clr_cnt == ADDR_W'(CELLS - 1)) state <= IDLE;
      else clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end

  assign clearing     = (state == CLEAR);
  assign clr_addr     = clr_cnt;
  // Pending host writes, including one handshaken this cycle, are discarded.
  assign flush        = (state == IDLE) && clear_req_i;
  assign clear_busy_o = clearing;
  assign host_ready_o = !fifo_full && (state == IDLE);
`else
  logic clear_req_unused;

  assign clear_req_unused = clear_req_i;
  assign clearing         = 1'b0;
  assign clr_addr         = '0;
  assign flush            = 1'b0;
  assign clear_busy_o     = 1'b0;
  assign host_ready_o     = !fifo_full;
`endif

  textbuf_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (accept && in_range),
    .push_data ({host_addr_i, host_data_i}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Buffer port mux: video, then clear engine, then oldest queued host write.
  always_comb begin
    buf_en_o   = 1'b0;
    buf_we_o   = 1'b0;
    buf_addr_o = vid_addr_i;
    buf_data_o = '0;
    pop        = 1'b0;
    if (vid_active_i) begin
      buf_en_o = 1'b1;
    end else if (clearing) begin
      buf_en_o   = 1'b1;
      buf_we_o   = 1'b1;
      buf_addr_o = clr_addr;
      buf_data_o = FILL_CHAR;
    end else if (!fifo_empty) begin
      buf_en_o   = 1'b1;
      buf_we_o   = 1'b1;
      buf_addr_o = head[ENT_W-1:CHAR_W];
      buf_data_o = head[CHAR_W-1:0];
      pop        = 1'b1;
    end
  end

  // One-cycle pulse after an out-of-range handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_o <= 1'b0;
    else     drop_o <= accept && !in_range;
  end

endmodule

// File: tb/tb_textbuf_access_ctrl.sv
// Self-checking bench for textbuf_access_ctrl (default geometry 80x60).
// Works with or without TEXTBUF_CLEAR_EN defined.
module tb_textbuf_access_ctrl;
  import textbuf_pkg::*;

  localparam int unsigned AW    = ADDR_W;
  localparam int unsigned CW    = CHAR_W_DEF;
  localparam int          CELLS = 4800;
  localparam int          QDEP  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          vid_active;
  logic [AW-1:0] vid_addr;
  logic          host_valid;
  logic          host_ready;
  logic [AW-1:0] host_addr;
  logic [CW-1:0] host_data;
  logic          clear_req;
  logic          clear_busy;
  logic          buf_en;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [CW-1:0] buf_data;
  logic          drop;

  textbuf_access_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .vid_active_i (vid_active),
    .vid_addr_i   (vid_addr),
    .host_valid_i (host_valid),
    .host_ready_o (host_ready),
    .host_addr_i  (host_addr),
    .host_data_i  (host_data),
    .clear_req_i  (clear_req),
    .clear_busy_o (clear_busy),
    .buf_en_o     (buf_en),
    .buf_we_o     (buf_we),
    .buf_addr_o   (buf_addr),
    .buf_data_o   (buf_data),
    .drop_o       (drop)
  );

  always #5 clk = ~clk;

  // Reference model: queue of accepted host writes tagged with acceptance cycle,
  // plus an abstract clear progress index.
  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t q[$];
  int  cyc;
  bit  clr_active;
  int  clr_idx;
  bit  drop_pend;
  bit  acc_drop;
  bit  mon_en;
  int  n_pass;
  int  n_total;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int n_old();
    int n = 0;
    foreach (q[i]) if (q[i].cyc < cyc) n++;
    return n;
  endfunction

  // One clock of stimulus; the handshake outcome is predicted by the model.
  task automatic step(input bit va, input int vaddr, input bit hv, input int haddr,
                      input int hdata, input bit creq, output bit acc);
    wr_t e;
    @(posedge clk);
    cyc++;
    #1;
    vid_active = va;
    vid_addr   = AW'(vaddr);
    host_valid = hv;
    host_addr  = AW'(haddr);
    host_data  = CW'(hdata);
    clear_req  = creq;
    acc        = 1'b0;
    acc_drop   = 1'b0;
    if (hv && n_old() < QDEP && !clr_active) begin
      acc = 1'b1;
      if (haddr < CELLS) begin
        e.addr = haddr;
        e.data = hdata;
        e.cyc  = cyc;
        q.push_back(e);
      end else begin
        acc_drop = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 0, 1'b0, a);
  endtask

  // Monitor: compares what the DUT presents against the model each cycle.
  always @(negedge clk) begin
    bit            busy_now;
    bit            ex_en;
    bit            ex_we;
    int            ex_addr;
    int            ex_data;
    if (mon_en) begin
      busy_now = clr_active;
      chk("host_ready", 32'(host_ready), 32'(n_old() < QDEP && !clr_active));
      chk("clear_busy", 32'(clear_busy), 32'(clr_active));
      chk("drop", 32'(drop), 32'(drop_pend));
      ex_en   = 1'b0;
      ex_we   = 1'b0;
      ex_addr = int'(vid_addr);
      ex_data = 0;
      if (vid_active) begin
        ex_en = 1'b1;
      end else if (clr_active) begin
        ex_en   = 1'b1;
        ex_we   = 1'b1;
        ex_addr = clr_idx;
        ex_data = 'h20;
        clr_idx++;
        if (clr_idx == CELLS) clr_active = 1'b0;
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        ex_en   = 1'b1;
        ex_we   = 1'b1;
        ex_addr = q[0].addr;
        ex_data = q[0].data;
        void'(q.pop_front());
      end
      chk("buf_en", 32'(buf_en), 32'(ex_en));
      chk("buf_we", 32'(buf_we), 32'(ex_we));
      chk("buf_addr", 32'(buf_addr), 32'(ex_addr));
      if (ex_we || vid_active) chk("buf_data", 32'(buf_data), 32'(ex_data));
      drop_pend = acc_drop;
`ifdef TEXTBUF_CLEAR_EN
      if (!busy_now && clear_req) begin
        clr_active = 1'b1;
        clr_idx    = 0;
        q.delete();
      end
`endif
    end
  end

  initial begin
    bit acc;
    n_pass = 0; n_total = 0; cyc = 0; mon_en = 1'b0;
    clr_active = 1'b0; clr_idx = 0; drop_pend = 1'b0; acc_drop = 1'b0;
    vid_active = 1'b0; vid_addr = '0; host_valid = 1'b0; host_addr = '0;
    host_data = '0; clear_req = 1'b0; rst = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(clear_busy), 0);
    chk("rst_we", 32'(buf_we), 0);
    chk("rst_drop", 32'(drop), 0);
    @(negedge clk) rst = 1'b0;
    #1 chk("rst_ready", 32'(host_ready), 1);
    mon_en = 1'b1;

    // Video fetch passthrough
    step(1'b1, 1234, 1'b0, 0, 0, 1'b0, acc);
    step(1'b1, 4799, 1'b0, 0, 0, 1'b0, acc);

    // Single write during active, lands on first blank cycle
    step(1'b1, 7, 1'b1, 5, 'h41, 1'b0, acc);
    step(1'b1, 8, 1'b0, 0, 0, 1'b0, acc);
    step(1'b1, 9, 1'b0, 0, 0, 1'b0, acc);
    idle(3);

    // Five back-to-back writes while active; fifth waits for space
    for (int i = 0; i < 5; i++) step(1'b1, 100 + i, 1'b1, 10 + i, 'h60 + i, 1'b0, acc);
    chk("fifth_held", 32'(acc), 0);
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) step(k >= 3 ? 1'b0 : 1'b1, 0, 1'b1, 14, 'h64, 1'b0, acc);
    chk("fifth_accepted", 32'(acc), 1);
    idle(8);

    // Out-of-range write drops
    step(1'b0, 0, 1'b1, 4800, 'h33, 1'b0, acc);
    step(1'b0, 0, 1'b1, 8191, 'h34, 1'b0, acc);
    idle(3);

`ifdef TEXTBUF_CLEAR_EN
    // Clear with a same-cycle host write that must be flushed
    step(1'b1, 0, 1'b1, 20, 'h11, 1'b0, acc);
    step(1'b0, 0, 1'b1, 77, 'h55, 1'b1, acc);
    for (int i = 0; i < CELLS + 2; i++)
      step(1'b0, 0, ($urandom_range(0, 3) == 0), $urandom_range(0, 4799), $urandom_range(0, 255),
           ($urandom_range(0, 50) == 0), acc);
    idle(4);

    // Clear with video toggling
    step(1'b0, 0, 1'b0, 0, 0, 1'b1, acc);
    for (int k = 0; k < 3 * CELLS && clr_active; k++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 4799), 1'b0, 0, 0, 1'b0, acc);
    chk("clear_done", 32'(clr_active), 0);
    idle(4);

    // Reset in the middle of a clear
    step(1'b0, 0, 1'b0, 0, 0, 1'b1, acc);
    for (int k = 0; k < 200 && clr_idx < 100; k++) step(1'b0, 0, 1'b0, 0, 0, 1'b0, acc);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk("midclr_busy", 32'(clear_busy), 0);
    chk("midclr_we", 32'(buf_we), 0);
    q.delete();
    clr_active = 1'b0; clr_idx = 0; drop_pend = 1'b0; acc_drop = 1'b0;
    @(negedge clk) rst = 1'b0;
    #1 chk("midclr_ready", 32'(host_ready), 1);
    mon_en = 1'b1;
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int ha;
      ha = ($urandom_range(0, 9) == 0) ? $urandom_range(4800, 8191) : $urandom_range(0, 4799);
      step($urandom_range(0, 1) == 1, $urandom_range(0, 4799), $urandom_range(0, 9) < 6, ha,
           $urandom_range(0, 255), $urandom_range(0, 999) == 0, acc);
    end
    for (int k = 0; k < 3 * CELLS && clr_active; k++) idle(1);
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
